// File: rtl/sr_latch_controller_pkg.sv
// sr_latch_controller_pkg: shared FSM state and op encodings for the SR latch controller
//   state_t    : IDLE / DRIVE / SETTLE / CHECK
//   OP_SET/RST : requester op encoding (1 = set, 0 = reset)
//   clog2_min1 : clog2 clamped to a minimum width of 1
package sr_latch_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SETTLE = 2'd2,
        ST_CHECK  = 2'd3
    } state_t;

    localparam logic OP_SET = 1'b1;
    localparam logic OP_RST = 1'b0;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sr_latch_controller_rr_arbiter.sv
// rr_arbiter: combinational round-robin grant, highest priority at ptr
//   req    in  NREQ  request vector
//   ptr    in  PW    requester with highest priority this round
//   gnt    out NREQ  one-hot grant (0 when no request)
//   gnt_id out PW    binary id of the granted requester
module rr_arbiter
    import sr_latch_controller_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int PW   = clog2_min1(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [PW-1:0]   gnt_id
);

    // Scan from the farthest to the nearest position after ptr so the last
    // hit written is the closest requester; no "found" flag needed.
    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[(int'(ptr) + i) % NREQ]) begin
                gnt    = NREQ'(1) << ((int'(ptr) + i) % NREQ);
                gnt_id = PW'((int'(ptr) + i) % NREQ);
            end
        end
    end

endmodule

// File: rtl/sr_latch_controller.sv
// sr_latch_controller: round-robin sequencing of set/reset requests onto an SR latch bank
//   clk      in  1          rising-edge clock
//   rst_n    in  1          asynchronous active-low reset
//   req      in  NREQ       per-requester request, held until ack
//   op       in  NREQ       per-requester op: 1 = set, 0 = reset
//   idx      in  NREQ*IDXW  per-requester latch index, slice i = [i*IDXW +: IDXW]
//   ack      out NREQ       one-cycle one-hot completion pulse
//   err      out NREQ       with ack: readback mismatch or out-of-range index
//   busy     out 1          controller not in IDLE
//   latch_s  out NFLAG      set drive to latch bank
//   latch_r  out NFLAG      reset drive to latch bank
//   latch_q  in  NFLAG      latch Q readback
module sr_latch_controller
    import sr_latch_controller_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int NFLAG     = 8,
    parameter int IDXW      = 3,
    parameter int PULSE_CYC = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      op,
    input  logic [NREQ*IDXW-1:0] idx,
    output logic [NREQ-1:0]      ack,
    output logic [NREQ-1:0]      err,
    output logic                 busy,
    output logic [NFLAG-1:0]     latch_s,
    output logic [NFLAG-1:0]     latch_r,
    input  logic [NFLAG-1:0]     latch_q
);

    localparam int PW = clog2_min1(NREQ);
    localparam int CW = clog2_min1(PULSE_CYC + 1);

    state_t            state_q, state_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [PW-1:0]     w_q, w_d;
    logic [NREQ-1:0]   own_q, own_d;
    logic              op_q, op_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic              bad_q, bad_d;
    logic [NREQ-1:0]   ack_q, ack_d;
    logic [NREQ-1:0]   err_q, err_d;
    logic              busy_q, busy_d;
    logic [NFLAG-1:0]  s_q, s_d;
    logic [NFLAG-1:0]  r_q, r_d;
    logic [NREQ-1:0]   gnt;
    logic [PW-1:0]     gnt_id;
    logic [IDXW-1:0]   idx_sel;
    logic [(1<<IDXW)-1:0] q_ext;

    rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
        .req    (req),
        .ptr    (ptr_q),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    assign idx_sel = idx[int'(gnt_id) * IDXW +: IDXW];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            w_q     <= '0;
            own_q   <= '0;
            op_q    <= 1'b0;
            idx_q   <= '0;
            bad_q   <= 1'b0;
            ack_q   <= '0;
            err_q   <= '0;
            busy_q  <= 1'b0;
            s_q     <= '0;
            r_q     <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            w_q     <= w_d;
            own_q   <= own_d;
            op_q    <= op_d;
            idx_q   <= idx_d;
            bad_q   <= bad_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            s_q     <= s_d;
            r_q     <= r_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        w_d     = w_q;
        own_d   = own_q;
        op_d    = op_q;
        idx_d   = idx_q;
        bad_d   = bad_q;
        case (state_q)
            ST_IDLE: if (|req) begin
                w_d     = gnt_id;
                own_d   = gnt;
                op_d    = |(op & gnt);
                idx_d   = idx_sel;
                bad_d   = int'(idx_sel) >= NFLAG;
                cnt_d   = '0;
                state_d = bad_d ? ST_CHECK : ST_DRIVE;
            end
            ST_DRIVE: begin
                cnt_d   = (cnt_q == CW'(PULSE_CYC - 1)) ? '0 : cnt_q + 1'b1;
                state_d = (cnt_q == CW'(PULSE_CYC - 1)) ? ST_SETTLE : ST_DRIVE;
            end
            ST_SETTLE: state_d = ST_CHECK;
            ST_CHECK: begin
                ptr_d   = (int'(w_q) + 1 == NREQ) ? '0 : w_q + 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so every output is a flop that
    // lines up exactly with the state it belongs to.
    always_comb begin
        q_ext              = '0;
        q_ext[NFLAG-1:0]   = latch_q;
        busy_d = state_d != ST_IDLE;
        ack_d  = (state_d == ST_CHECK) ? own_d : '0;
        err_d  = (state_d == ST_CHECK && (bad_d || q_ext[idx_d] != op_d)) ? own_d : '0;
        s_d    = (state_d == ST_DRIVE && op_d == OP_SET) ? NFLAG'(1) << idx_d : '0;
        r_d    = (state_d == ST_DRIVE && op_d == OP_RST) ? NFLAG'(1) << idx_d : '0;
    end

    assign ack     = ack_q;
    assign err     = err_q;
    assign busy    = busy_q;
    assign latch_s = s_q;
    assign latch_r = r_q;

endmodule

// File: tb/tb_sr_latch_controller.sv
// tb_sr_latch_controller: directed bench with a behavioural SR latch bank
module tb_sr_latch_controller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req_v = '0, op_v = '0;
    logic [11:0] idx_v = '0;
    logic [3:0]  ack, err;
    logic        busy;
    logic [7:0]  latch_s, latch_r, latch_q;
    logic [7:0]  fault = 8'h00;
    logic [7:0]  q_bank = 8'h00;

    logic [3:0]  req_b = '0, op_b = '0;
    logic [11:0] idx_b = '0;
    logic [3:0]  ack_b, err_b;
    logic        busy_b;
    logic [5:0]  s_b, r_b;
    logic [5:0]  q_b = 6'h00;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign latch_q = q_bank & ~fault;

    always @(posedge clk)
        for (int i = 0; i < 8; i++)
            if (latch_s[i]) q_bank[i] <= 1'b1;
            else if (latch_r[i]) q_bank[i] <= 1'b0;

    sr_latch_controller #(.NREQ(4), .NFLAG(8), .IDXW(3), .PULSE_CYC(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .req(req_v), .op(op_v), .idx(idx_v),
        .ack(ack), .err(err), .busy(busy),
        .latch_s(latch_s), .latch_r(latch_r), .latch_q(latch_q)
    );

    sr_latch_controller #(.NREQ(4), .NFLAG(6), .IDXW(3), .PULSE_CYC(2)) u_bad (
        .clk(clk), .rst_n(rst_n), .req(req_b), .op(op_b), .idx(idx_b),
        .ack(ack_b), .err(err_b), .busy(busy_b),
        .latch_s(s_b), .latch_r(r_b), .latch_q(q_b)
    );

    typedef struct {
        int         id;
        logic       op;
        logic [2:0] ix;
        logic [7:0] flt;
        logic [7:0] s;
        logic [7:0] r;
        logic       e;
    } vec_t;

    vec_t vt[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(output int id, output int cyc);
        cyc = 0;
        id  = -1;
        do begin
            tick();
            cyc++;
        end while (ack == 4'b0 && cyc < 30);
        for (int i = 0; i < 4; i++) if (ack[i]) id = i;
        if (ack == 4'b0) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout got no ack want ack within 30 cycles");
        end
    endtask

    // S and R exclusivity and at most one active drive line, every cycle
    always @(negedge clk) begin
        chk("s_and_r", 32'(latch_s & latch_r), 0);
        chk("one_drive", 32'($countones(latch_s | latch_r) > 1), 0);
        chk("bad_no_drive", 32'({s_b, r_b}), 0);
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        errors++;
        $fatal(1, "watchdog");
    end

    initial begin
        int id, cyc;
        int exp_order[4];
        vt[0] = '{0, 1'b1, 3'd5, 8'h00, 8'h20, 8'h00, 1'b0};
        vt[1] = '{1, 1'b1, 3'd2, 8'h04, 8'h04, 8'h00, 1'b1};
        vt[2] = '{2, 1'b0, 3'd5, 8'h00, 8'h00, 8'h20, 1'b0};
        vt[3] = '{3, 1'b1, 3'd7, 8'h00, 8'h80, 8'h00, 1'b0};
        vt[4] = '{0, 1'b0, 3'd0, 8'h00, 8'h00, 8'h01, 1'b0};
        vt[5] = '{1, 1'b0, 3'd2, 8'h00, 8'h00, 8'h04, 1'b0};
        exp_order = '{0, 1, 3, 0};

        // reset held with every requester active
        req_v = 4'hF;
        op_v  = 4'hF;
        idx_v = {3'd6, 3'd4, 3'd3, 3'd1};
        tick();
        tick();
        chk("rst_ack", 32'(ack), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_s", 32'(latch_s), 0);
        chk("rst_r", 32'(latch_r), 0);
        rst_n = 1'b1;
        wait_ack(id, cyc);
        chk("first_grant", id, 0);
        chk("first_latency", cyc, 4);
        req_v = '0;
        tick();
        chk("idle_busy", 32'(busy), 0);

        // single operations, one per table row
        for (int v = 0; v < 6; v++) begin
            req_v[vt[v].id] = 1'b1;
            op_v[vt[v].id]  = vt[v].op;
            idx_v[vt[v].id*3 +: 3] = vt[v].ix;
            fault = vt[v].flt;
            tick();
            chk($sformatf("v%0d_s1", v), 32'(latch_s), 32'(vt[v].s));
            chk($sformatf("v%0d_r1", v), 32'(latch_r), 32'(vt[v].r));
            chk($sformatf("v%0d_busy", v), 32'(busy), 1);
            tick();
            chk($sformatf("v%0d_s2", v), 32'(latch_s), 32'(vt[v].s));
            chk($sformatf("v%0d_r2", v), 32'(latch_r), 32'(vt[v].r));
            tick();
            chk($sformatf("v%0d_settle", v), 32'(latch_s | latch_r), 0);
            chk($sformatf("v%0d_noack", v), 32'(ack), 0);
            tick();
            chk($sformatf("v%0d_ack", v), 32'(ack), 32'(4'b0001 << vt[v].id));
            chk($sformatf("v%0d_err", v), 32'(err), 32'({3'b000, vt[v].e} << vt[v].id));
            chk($sformatf("v%0d_q", v), 32'(q_bank[vt[v].ix]), 32'(vt[v].op));
            req_v[vt[v].id] = 1'b0;
            tick();
            chk($sformatf("v%0d_idle", v), 32'(busy), 0);
            chk($sformatf("v%0d_ackoff", v), 32'(ack), 0);
            fault = 8'h00;
        end

        // round robin from a fresh pointer with 0, 1 and 3 requesting
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        op_v  = 4'hF;
        idx_v = {3'd6, 3'd0, 3'd3, 3'd1};
        req_v = 4'b1011;
        for (int k = 0; k < 4; k++) begin
            wait_ack(id, cyc);
            chk($sformatf("rr_order%0d", k), id, exp_order[k]);
            chk($sformatf("rr_period%0d", k), cyc, (k == 0) ? 4 : 5);
        end
        req_v = '0;
        tick();

        // out-of-range indices on the 6-latch instance, including idx == NFLAG
        op_b  = 4'hF;
        idx_b = {3'd6, 3'd7, 3'd0, 3'd0};
        req_b = 4'b0100;
        tick();
        chk("bad7_ack", 32'(ack_b), 32'(4'b0100));
        chk("bad7_err", 32'(err_b), 32'(4'b0100));
        chk("bad7_busy", 32'(busy_b), 1);
        req_b = 4'b1000;
        tick();
        chk("bad_idle_ack", 32'(ack_b), 0);
        chk("bad_idle_busy", 32'(busy_b), 0);
        tick();
        chk("bad6_ack", 32'(ack_b), 32'(4'b1000));
        chk("bad6_err", 32'(err_b), 32'(4'b1000));
        req_b = '0;
        tick();
        chk("bad_done", 32'(busy_b), 0);

        // async reset in the middle of a set pulse; pointer was 1 beforehand
        req_v = 4'b0001;
        idx_v = {3'd6, 3'd0, 3'd0, 3'd3};
        tick();
        chk("mid_s", 32'(latch_s), 32'(8'h08));
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_s", 32'(latch_s), 0);
        chk("async_busy", 32'(busy), 0);
        chk("async_ack", 32'(ack), 0);
        req_v = 4'b1001;
        idx_v = {3'd6, 3'd0, 3'd0, 3'd4};
        tick();
        rst_n = 1'b1;
        wait_ack(id, cyc);
        chk("post_rst_grant", id, 0);
        chk("post_rst_latency", cyc, 4);
        req_v = '0;
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
